pwm_freq_sequencer: RTL and testbench

Parametrised PWM frequency sequencer: steps the PWM divider value through a table of up to DEPTH frequency phases instead of toggling between a fixed high/low pair. Each phase holds for a programmable number of `done` pulses from the downstream PWM counter. The sequence runs once or loops, and can be started and aborted. The block sits between the control registers and the PWM counter; `freq_out` drives the counter's period input.

---
 rtl/pwm_seq_pkg.sv | 27 ++
 rtl/pwm_dwell_counter.sv | 28 ++
 rtl/pwm_freq_sequencer.sv | 130 +++++++++++++
 tb/tb_pwm_freq_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM frequency sequencer.
// The helpers take 32-bit operands so every parameterisation can use them.
package pwm_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Active phase count: 0 means 1 phase, anything above the table depth means all of it.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] depth);
        logic [31:0] result;
        if (len == 32'd0)
            result = 32'd1;
        else if (len > depth)
            result = depth;
        else
            result = len;
        return result;
    endfunction

    // A repeat count of 0 dwells for a single done pulse, the same as 1.
    function automatic logic [31:0] norm_rep(input logic [31:0] rep);
        return (rep == 32'd0) ? 32'd1 : rep;
    endfunction

endpackage

// File: rtl/pwm_dwell_counter.sv
// Counts done pulses within one phase.
// terminal is high when the next counted pulse completes the phase.
module pwm_dwell_counter #(
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    input  logic [RW-1:0] limit,
    output logic          terminal
);

    logic [RW-1:0] count_q;
    logic [RW:0]   count_plus_one;

    // The compare is one bit wider, so a limit of 2^RW-1 still terminates.
    assign count_plus_one = {1'b0, count_q} + {{RW{1'b0}}, 1'b1};
    assign terminal       = (count_plus_one >= {1'b0, limit});

    always_ff @(posedge clk) begin
        if (reset || clear)
            count_q <= '0;
        else if (inc)
            count_q <= count_q + {{(RW-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/pwm_freq_sequencer.sv
// Steps the PWM period word through a table of phases, each held for a set
// number of done pulses, once or in a loop; start/stop/done are one-cycle pulses.
module pwm_freq_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int RW    = 8,
    parameter int LW    = $clog2(DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DEPTH*WIDTH-1:0]   freq_tbl,
    input  logic [DEPTH*RW-1:0]      rep_tbl,
    input  logic [LW-1:0]            len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     done,
    output logic [WIDTH-1:0]         freq_out,
    output logic [$clog2(DEPTH)-1:0] phase_idx,
    output logic                     busy,
    output logic                     seq_end
);

    localparam int PW = $clog2(DEPTH);

    seq_state_t     state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [LW-1:0]  len_q, len_d;
    logic           loop_q, loop_d;
    logic           seq_end_q, seq_end_d;
    logic [WIDTH-1:0] freq_q;

    logic [WIDTH-1:0] freq_arr [DEPTH];
    logic [RW-1:0]    rep_arr  [DEPTH];
    logic [RW-1:0]    rep_cur;
    logic             cnt_clear, cnt_inc, cnt_terminal;
    logic             last_phase;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign freq_arr[i] = freq_tbl[i*WIDTH +: WIDTH];
        assign rep_arr[i]  = rep_tbl[i*RW +: RW];
    end

    assign rep_cur    = RW'(norm_rep(32'(rep_arr[phase_q])));
    assign last_phase = (LW'(phase_q) == (len_q - {{(LW-1){1'b0}}, 1'b1}));

    pwm_dwell_counter #(.RW(RW)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .limit    (rep_cur),
        .terminal (cnt_terminal)
    );

    // stop outranks done and start; in IDLE a coincident done is dropped.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        loop_d    = loop_q;
        seq_end_d = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d   = '0;
                cnt_clear = 1'b1;
                if (start && !stop) begin
                    state_d = RUN;
                    len_d   = LW'(clamp_len(32'(len), 32'(DEPTH)));
                    loop_d  = loop_en;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    phase_d   = '0;
                    cnt_clear = 1'b1;
                end else if (done) begin
                    if (!cnt_terminal) begin
                        cnt_inc = 1'b1;
                    end else begin
                        cnt_clear = 1'b1;
                        if (last_phase) begin
                            seq_end_d = 1'b1;
                            phase_d   = '0;
                            if (!loop_q)
                                state_d = IDLE;
                        end else begin
                            phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                phase_d   = '0;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // freq_out follows the next phase so a phase change reaches the counter one cycle after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            len_q     <= {{(LW-1){1'b0}}, 1'b1};
            loop_q    <= 1'b0;
            seq_end_q <= 1'b0;
            freq_q    <= freq_arr[0];
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            seq_end_q <= seq_end_d;
            freq_q    <= freq_arr[phase_d];
        end
    end

    assign freq_out  = freq_q;
    assign phase_idx = phase_q;
    assign busy      = (state_q == RUN);
    assign seq_end   = seq_end_q;

endmodule

// File: tb/tb_pwm_freq_sequencer.sv
// Directed bench for pwm_freq_sequencer with hand-computed expectations.
module tb_pwm_freq_sequencer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int RW    = 8;
    localparam int LW    = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DEPTH*WIDTH-1:0] freq_tbl;
    logic [DEPTH*RW-1:0]    rep_tbl;
    logic [LW-1:0]          len;
    logic                   loop_en;
    logic                   start;
    logic                   stop;
    logic                   done;
    logic [WIDTH-1:0]       freq_out;
    logic [1:0]             phase_idx;
    logic                   busy;
    logic                   seq_end;

    int total = 0;
    int bad   = 0;

    pwm_freq_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .freq_tbl  (freq_tbl),
        .rep_tbl   (rep_tbl),
        .len       (len),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .done      (done),
        .freq_out  (freq_out),
        .phase_idx (phase_idx),
        .busy      (busy),
        .seq_end   (seq_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge, outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    int exp_ph [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};

    initial begin
        reset    = 1'b1;
        freq_tbl = {32'd40, 32'd30, 32'd20, 32'd10};
        rep_tbl  = {8'd1, 8'd1, 8'd1, 8'd1};
        len      = 3'd3;
        loop_en  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        done     = 1'b0;
        #1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_freq", freq_out, 10);
        check("rst_busy", busy, 0);
        check("rst_phase", phase_idx, 0);
        check("rst_seq_end", seq_end, 0);

        // one-shot, 3 phases, one done each
        pulse_done();
        check("idle_done_ignored", busy, 0);
        pulse_start();
        check("os_busy", busy, 1);
        check("os_freq0", freq_out, 10);
        pulse_done();
        check("os_freq1", freq_out, 20);
        check("os_phase1", phase_idx, 1);
        check("os_end1", seq_end, 0);
        pulse_done();
        check("os_freq2", freq_out, 30);
        pulse_done();
        check("os_freq_wrap", freq_out, 10);
        check("os_end3", seq_end, 1);
        check("os_busy_end", busy, 0);
        check("os_phase_end", phase_idx, 0);
        tick();
        check("os_end_one_cycle", seq_end, 0);
        pulse_done();
        check("os_after_freq", freq_out, 10);
        check("os_after_busy", busy, 0);

        // looping, len 2, phase 0 x2, phase 1 x3, back-to-back dones
        rep_tbl = {8'd0, 8'd0, 8'd3, 8'd2};
        len     = 3'd2;
        loop_en = 1'b1;
        pulse_start();
        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("loop_phase_%0d", i), phase_idx, exp_ph[i]);
            check($sformatf("loop_freq_%0d", i), freq_out, (exp_ph[i] + 1) * 10);
            check($sformatf("loop_end_%0d", i), seq_end, (i == 4 || i == 9) ? 1 : 0);
            check($sformatf("loop_busy_%0d", i), busy, 1);
        end
        done = 1'b0;
        pulse_stop();
        check("loop_stopped", busy, 0);

        // stop coincident with the second done of a rep=2 phase
        loop_en = 1'b0;
        pulse_start();
        pulse_done();
        check("stop_pre_phase", phase_idx, 0);
        done = 1'b1;
        stop = 1'b1;
        tick();
        done = 1'b0;
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_phase", phase_idx, 0);
        check("stop_no_end", seq_end, 0);
        check("stop_freq", freq_out, 10);
        pulse_start();
        pulse_done();
        check("restart_cnt_cleared", phase_idx, 0);
        pulse_done();
        check("restart_phase1", phase_idx, 1);
        pulse_start();
        check("start_in_run_ignored", phase_idx, 1);
        check("start_in_run_freq", freq_out, 20);
        pulse_stop();

        // start with done in IDLE: start taken, done dropped
        rep_tbl = {8'd1, 8'd1, 8'd1, 8'd1};
        start = 1'b1;
        done  = 1'b1;
        tick();
        start = 1'b0;
        done  = 1'b0;
        check("start_done_busy", busy, 1);
        check("start_done_phase", phase_idx, 0);
        pulse_done();
        check("start_done_next", phase_idx, 1);
        pulse_stop();

        // len 0 acts as 1, rep 0 acts as 1, looping
        rep_tbl = {8'd0, 8'd0, 8'd0, 8'd0};
        len     = 3'd0;
        loop_en = 1'b1;
        pulse_start();
        pulse_done();
        check("len0_phase", phase_idx, 0);
        check("len0_end_a", seq_end, 1);
        check("len0_busy", busy, 1);
        check("len0_freq", freq_out, 10);
        pulse_done();
        check("len0_end_b", seq_end, 1);
        pulse_stop();

        // len 7 clamps to 4
        len = 3'd7;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            pulse_done();
            check($sformatf("len7_phase_%0d", i), phase_idx, (i + 1) % 4);
            check($sformatf("len7_freq_%0d", i), freq_out, (((i + 1) % 4) + 1) * 10);
            check($sformatf("len7_end_%0d", i), seq_end, (i == 3) ? 1 : 0);
        end
        check("len7_busy", busy, 1);
        pulse_stop();

        // live table edits in IDLE and RUN
        freq_tbl[31:0] = 32'd55;
        tick();
        check("edit_idle", freq_out, 55);
        pulse_start();
        freq_tbl[31:0] = 32'd77;
        tick();
        check("edit_run", freq_out, 77);
        freq_tbl[31:0] = 32'd10;
        pulse_stop();

        // reset mid-run at phase 2, start in the reset cycle ignored
        rep_tbl = {8'd1, 8'd1, 8'd1, 8'd1};
        len     = 3'd4;
        pulse_start();
        pulse_done();
        pulse_done();
        check("pre_rst_phase", phase_idx, 2);
        check("pre_rst_freq", freq_out, 30);
        reset = 1'b1;
        start = 1'b1;
        done  = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_freq", freq_out, 10);
        check("mid_rst_end", seq_end, 0);
        check("mid_rst_phase", phase_idx, 0);
        tick();
        check("mid_rst_start_ignored", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
